vga_sprite_mux: RTL and testbench
=================================

VGA_SPRITE_MUX -- requirements
Module: vga_sprite_mux

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- NSPR, 2, number of sprite windows (1..4); index 0 has highest priority.
- ADDR_W, 17, sprite ROM address width.
- ROM_LAT, 1, sprite ROM read latency in clk cycles (1..3).
- H_START, 144, first visible posx; H_END, 783, last visible posx.
- V_START, 35, first visible posy; V_END, 514, last visible posy.
- BG, 12'hfff, background colour.
- KEY, 12'h0f0, transparent colour key.

REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, pixel clock.
- rst_n, in, 1, asynchronous active-low reset.
- ena, in, 1, screen enable.
- posx, in, 16, current scan column.
- posy, in, 16, current scan row.
- cfg_we, in, 1, write one sprite's shadow configuration.
- cfg_idx, in, 2, sprite index for the write.
- cfg_x, in, 16, sprite origin column.
- cfg_y, in, 16, sprite origin row.
- cfg_w, in, 10, sprite width.
- cfg_h, in, 10, sprite height.
- cfg_on, in, 1, sprite visible.
- rom_addr, out, NSPR*ADDR_W, per-sprite ROM address; sprite i occupies bits [i*ADDR_W +: ADDR_W].
- rom_data, in, NSPR*12, per-sprite ROM data, valid ROM_LAT cycles after rom_addr.
- RGB, out, 12, output pixel colour.

Function
REQ-003 Each sprite has a shadow register set and an active register set; cfg_we writes the shadow set of cfg_idx in the same cycle; a cfg_idx >= NSPR SHALL be ignored.
REQ-004 Shadow sets SHALL copy to the active sets in the cycle where posx==0 and posy==0, so positions never change mid-frame; a cfg_we in that same cycle SHALL land in shadow and commit at the next frame.
REQ-005 Stage 0 (registered): sprite i hits when it is on, the pixel is visible, posx is in [x_i, x_i+w_i-1] and posy is in [y_i, y_i+h_i-1]; all comparisons are 17-bit unsigned so that x_i+w_i cannot wrap.
REQ-006 Stage 0 SHALL drive rom_addr_i = (posy-y_i)*w_i + (posx-x_i), truncated to ADDR_W; on a miss, rom_addr_i SHALL hold its previous value.
REQ-007 Hit flags, the visible flag and ena SHALL be delayed ROM_LAT cycles so that they align with rom_data.
REQ-008 Output stage: if ena (delayed) is 0, RGB=0; else if the pixel is not visible, RGB=0 (border); else RGB is the lowest-index hit sprite whose rom_data is not KEY; else BG.
REQ-009 Total latency from posx/posy to RGB SHALL be ROM_LAT+1 cycles, fixed, with no bubbles; the block is fully pipelined at one pixel per cycle.
REQ-010 Zero width or zero height SHALL never hit.
REQ-011 Overlapping sprites SHALL resolve by priority per pixel; a KEY pixel falls through to the next hit sprite.
REQ-012 Deasserting ena mid-line SHALL affect only the pixels whose delayed ena is 0; configuration state is unaffected.

Reset
REQ-013 With rst_n low, asynchronously: RGB=0, rom_addr=0, all pipeline flags=0, and all shadow and active sets set to on=0, x=y=w=h=0.
REQ-014 After the release of rst_n, output SHALL be BG for visible pixels, with no sprites, until configuration has been committed at a frame start.

Verification
REQ-015 Reset: rst_n=0 mid-frame -> RGB=0 immediately; after release with ena=1 and pos (400,200) -> RGB=12'hfff after ROM_LAT+1 cycles.
REQ-016 Single sprite: sprite0 at (404,135), 120x90, committed; pos (405,137) -> rom_addr0=241, and RGB equals rom_data0 of that address ROM_LAT+1 cycles later.
REQ-017 Border: pos (143,200), (784,200), (400,34) and (400,515) -> RGB=0 regardless of sprites.
REQ-018 Priority and key: sprites 0 and 1 overlapping at (450,300); rom_data0=12'h0f0 and rom_data1=12'h123 -> RGB=12'h123; with rom_data0=12'h800 -> RGB=12'h800.
REQ-019 Shadow commit: cfg_we moves sprite0 mid-frame -> the old position is drawn for the rest of that frame; the new position takes effect from pos (0,0).
REQ-020 Edges and ena: x=783, w=1 hits only posx 783; cfg_idx=3 with NSPR=2 -> no change; ena=0 for one cycle -> exactly one RGB=0 pixel, ROM_LAT+1 cycles later.

Source files
------------

// File: rtl/vga_sprite_mux.sv
// Sprite overlay mixer for a VGA scan: per-pixel window hit, ROM address
// generation and priority/colour-key resolution, one pixel per clock.
module vga_sprite_mux #(
  parameter int          NSPR    = 2,
  parameter int          ADDR_W  = 17,
  parameter int          ROM_LAT = 1,
  parameter int          H_START = 144,
  parameter int          H_END   = 783,
  parameter int          V_START = 35,
  parameter int          V_END   = 514,
  parameter logic [11:0] BG      = 12'hfff,
  parameter logic [11:0] KEY     = 12'h0f0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic [15:0]              posx,
  input  logic [15:0]              posy,
  input  logic                     cfg_we,
  input  logic [1:0]               cfg_idx,
  input  logic [15:0]              cfg_x,
  input  logic [15:0]              cfg_y,
  input  logic [9:0]               cfg_w,
  input  logic [9:0]               cfg_h,
  input  logic                     cfg_on,
  output logic [NSPR*ADDR_W-1:0]   rom_addr,
  input  logic [NSPR*12-1:0]       rom_data,
  output logic [11:0]              RGB
);

  logic [15:0]       r_sx [NSPR];
  logic [15:0]       r_sy [NSPR];
  logic [9:0]        r_sw [NSPR];
  logic [9:0]        r_sh [NSPR];
  logic [NSPR-1:0]   r_son;

  logic [15:0]       r_ax [NSPR];
  logic [15:0]       r_ay [NSPR];
  logic [9:0]        r_aw [NSPR];
  logic [9:0]        r_ah [NSPR];
  logic [NSPR-1:0]   r_aon;

  logic              w_frame;
  logic              w_vis;
  logic [NSPR-1:0]   w_hit;
  logic [15:0]       w_dx [NSPR];
  logic [15:0]       w_dy [NSPR];
  logic [ADDR_W-1:0] w_addr [NSPR];
  logic [ADDR_W-1:0] r_addr [NSPR];

  // Index 0 is stage 0; index ROM_LAT lines up with rom_data.
  logic [NSPR-1:0]   r_hit_p [ROM_LAT+1];
  logic [ROM_LAT:0]  r_vis_p;
  logic [ROM_LAT:0]  r_ena_p;
  logic [11:0]       w_rgb;

  assign w_frame = (posx == 16'd0) && (posy == 16'd0);

  assign w_vis = (posx >= 16'(H_START)) && (posx <= 16'(H_END)) &&
                 (posy >= 16'(V_START)) && (posy <= 16'(V_END));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_son <= '0;
      r_aon <= '0;
      for (int i = 0; i < NSPR; i++) begin
        r_sx[i] <= '0;
        r_sy[i] <= '0;
        r_sw[i] <= '0;
        r_sh[i] <= '0;
        r_ax[i] <= '0;
        r_ay[i] <= '0;
        r_aw[i] <= '0;
        r_ah[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NSPR; i++) begin
        if (w_frame) begin
          r_ax[i]  <= r_sx[i];
          r_ay[i]  <= r_sy[i];
          r_aw[i]  <= r_sw[i];
          r_ah[i]  <= r_sh[i];
          r_aon[i] <= r_son[i];
        end
        if (cfg_we && (cfg_idx == 2'(i))) begin
          r_sx[i]  <= cfg_x;
          r_sy[i]  <= cfg_y;
          r_sw[i]  <= cfg_w;
          r_sh[i]  <= cfg_h;
          r_son[i] <= cfg_on;
        end
      end
    end
  end

  // 17-bit compares keep x+w and y+h from wrapping at the top of range.
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < NSPR; i++) begin
      w_dx[i]   = posx - r_ax[i];
      w_dy[i]   = posy - r_ay[i];
      w_addr[i] = ADDR_W'(32'(w_dy[i]) * 32'(r_aw[i]) + 32'(w_dx[i]));
      w_hit[i]  = r_aon[i] && w_vis &&
        ({1'b0, posx} >= {1'b0, r_ax[i]}) &&
        ({1'b0, posx} < ({1'b0, r_ax[i]} + 17'(r_aw[i]))) &&
        ({1'b0, posy} >= {1'b0, r_ay[i]}) &&
        ({1'b0, posy} < ({1'b0, r_ay[i]} + 17'(r_ah[i])));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vis_p <= '0;
      r_ena_p <= '0;
      for (int i = 0; i < NSPR; i++) begin
        r_addr[i] <= '0;
      end
      for (int k = 0; k <= ROM_LAT; k++) begin
        r_hit_p[k] <= '0;
      end
    end else begin
      r_vis_p[0] <= w_vis;
      r_ena_p[0] <= ena;
      r_hit_p[0] <= w_hit;
      for (int i = 0; i < NSPR; i++) begin
        if (w_hit[i]) r_addr[i] <= w_addr[i];
      end
      for (int k = 1; k <= ROM_LAT; k++) begin
        r_vis_p[k] <= r_vis_p[k-1];
        r_ena_p[k] <= r_ena_p[k-1];
        r_hit_p[k] <= r_hit_p[k-1];
      end
    end
  end

  for (genvar g = 0; g < NSPR; g++) begin : g_addr
    assign rom_addr[g*ADDR_W +: ADDR_W] = r_addr[g];
  end

  // Walk from lowest priority up so the lowest-index opaque hit wins.
  always_comb begin
    w_rgb = '0;
    if (r_ena_p[ROM_LAT] && r_vis_p[ROM_LAT]) begin
      w_rgb = BG;
      for (int i = NSPR - 1; i >= 0; i--) begin
        if (r_hit_p[ROM_LAT][i] && (rom_data[i*12 +: 12] != KEY))
          w_rgb = rom_data[i*12 +: 12];
      end
    end
  end

  assign RGB = w_rgb;

endmodule

// File: tb/tb_vga_sprite_mux.sv
// Directed bench for vga_sprite_mux with a one-cycle-latency ROM model.
module tb_vga_sprite_mux;

  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ena;
  logic [15:0]   posx;
  logic [15:0]   posy;
  logic          cfg_we;
  logic [1:0]    cfg_idx;
  logic [15:0]   cfg_x;
  logic [15:0]   cfg_y;
  logic [9:0]    cfg_w;
  logic [9:0]    cfg_h;
  logic          cfg_on;
  logic [2*AW-1:0] rom_addr;
  logic [23:0]   rom_data;
  logic [11:0]   RGB;

  logic          f0, f1;
  logic [11:0]   fv0, fv1;
  logic [11:0]   rd0 = '0;
  logic [11:0]   rd1 = '0;

  int n_chk = 0;
  int n_fail = 0;

  vga_sprite_mux dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .posx(posx), .posy(posy),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_x(cfg_x), .cfg_y(cfg_y),
    .cfg_w(cfg_w), .cfg_h(cfg_h), .cfg_on(cfg_on),
    .rom_addr(rom_addr), .rom_data(rom_data), .RGB(RGB)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] fn0(input logic [AW-1:0] a);
    return a[11:0] ^ 12'h5a5;
  endfunction

  function automatic logic [11:0] fn1(input logic [AW-1:0] a);
    return a[11:0] ^ 12'h3c3;
  endfunction

  always @(posedge clk) begin
    rd0 <= f0 ? fv0 : fn0(rom_addr[0 +: AW]);
    rd1 <= f1 ? fv1 : fn1(rom_addr[AW +: AW]);
  end

  assign rom_data = {rd1, rd0};

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic pix(input int x, input int y, input logic [11:0] exp,
                     input string tag);
    posx = 16'(x);
    posy = 16'(y);
    repeat (2) @(posedge clk);
    #1;
    chk(tag, 32'(RGB), 32'(exp));
  endtask

  task automatic cfg(input int idx, input int x, input int y,
                     input int w, input int h, input logic on);
    cfg_we  = 1'b1;
    cfg_idx = 2'(idx);
    cfg_x   = 16'(x);
    cfg_y   = 16'(y);
    cfg_w   = 10'(w);
    cfg_h   = 10'(h);
    cfg_on  = on;
    @(posedge clk);
    #1;
    cfg_we  = 1'b0;
  endtask

  task automatic commit();
    posx = 16'd0;
    posy = 16'd0;
    @(posedge clk);
    #1;
    posx = 16'd400;
    posy = 16'd200;
  endtask

  initial begin
    rst_n = 1'b1;
    ena = 1'b1;
    posx = 16'd400;
    posy = 16'd200;
    cfg_we = 1'b0;
    cfg_idx = '0;
    cfg_x = '0;
    cfg_y = '0;
    cfg_w = '0;
    cfg_h = '0;
    cfg_on = 1'b0;
    f0 = 1'b0;
    f1 = 1'b0;
    fv0 = '0;
    fv1 = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_rgb", 32'(RGB), 32'h0);
    chk("rst_addr", 32'(rom_addr), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    pix(400, 200, 12'hfff, "bg_after_rst");

    cfg(0, 404, 135, 120, 90, 1'b1);
    pix(405, 137, 12'hfff, "uncommitted");
    commit();
    posx = 16'd405;
    posy = 16'd137;
    @(posedge clk);
    #1;
    chk("addr0", 32'(rom_addr[0 +: AW]), 32'd241);
    @(posedge clk);
    #1;
    chk("spr0_rgb", 32'(RGB), 32'(fn0(17'd241)));

    cfg(1, 0, 0, 1023, 1023, 1'b1);
    commit();
    pix(143, 200, 12'h000, "border_l");
    pix(784, 200, 12'h000, "border_r");
    pix(400, 34, 12'h000, "border_t");
    pix(400, 515, 12'h000, "border_b");
    pix(400, 200, fn1(17'd73928), "spr1_rgb");

    cfg(0, 440, 290, 50, 50, 1'b1);
    pix(450, 300, fn1(17'd45206), "old_pos_miss");
    pix(405, 137, fn0(17'd241), "old_pos_drawn");
    commit();
    pix(405, 137, fn1(17'd9484), "new_pos_vacated");
    f0 = 1'b1;
    fv0 = 12'h0f0;
    f1 = 1'b1;
    fv1 = 12'h123;
    pix(450, 300, 12'h123, "key_fall");
    fv0 = 12'h800;
    pix(450, 300, 12'h800, "prio0");
    f0 = 1'b0;
    f1 = 1'b0;
    pix(450, 300, fn0(17'd510), "new_pos_drawn");

    cfg(3, 0, 0, 0, 0, 1'b0);
    commit();
    pix(405, 137, fn1(17'd9484), "idx3_ign_s1");
    pix(450, 300, fn0(17'd510), "idx3_ign_s0");

    cfg(0, 783, 200, 1, 10, 1'b1);
    cfg(1, 400, 200, 0, 10, 1'b1);
    commit();
    pix(782, 200, 12'hfff, "edge_left");
    pix(783, 200, fn0(17'd0), "edge_hit");
    pix(784, 200, 12'h000, "edge_right");
    pix(400, 200, 12'hfff, "zero_w");

    posx = 16'd400;
    posy = 16'd200;
    @(posedge clk);
    #1 ena = 1'b0;
    @(posedge clk);
    #1;
    ena = 1'b1;
    chk("ena_lat0", 32'(RGB), 32'hfff);
    @(posedge clk);
    #1;
    chk("ena_gap", 32'(RGB), 32'h000);
    @(posedge clk);
    #1;
    chk("ena_back", 32'(RGB), 32'hfff);

    #2 rst_n = 1'b0;
    #1;
    chk("midrst_rgb", 32'(RGB), 32'h0);
    chk("midrst_addr", 32'(rom_addr), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    pix(783, 200, 12'hfff, "cleared");

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
